// File: rtl/paritysel_operand_seq_if.sv
// Operand-sequencer bus: input word stream, held operand pair and sel beat stream.
// The slave side is the sequencer; the master side is the stimulus / downstream mux.
interface paritysel_operand_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic [4:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, data_a, data_b, sel, out_valid, out_last, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, data_a, data_b, sel, out_valid, out_last, busy
  );
endinterface

// File: rtl/paritysel_operand_seq.sv
// Captures an A/B operand pair, then steps sel over NUM_BEATS beats; first beat one cycle after B.
// Output beats hold under out_ready low; input is stalled (in_ready=0) for the whole emission.
module paritysel_operand_seq #(
  parameter int WIDTH     = 8,
  parameter int NUM_BEATS = 4
) (
  input logic                   clk,
  input logic                   rst,
  paritysel_operand_seq_if.slave bus
);

  typedef enum logic [1:0] {
    FILL_A = 2'd0,
    FILL_B = 2'd1,
    EMIT   = 2'd2
  } state_t;

  localparam logic [4:0] LAST_SEL = 5'(NUM_BEATS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_data_a;
  logic [WIDTH-1:0] r_data_b;
  logic [4:0]       r_sel;
  logic             r_out_valid;
  logic             r_out_last;
  logic             w_in_ready;
  logic             w_busy;
  logic             w_in_acc;
  logic             w_out_acc;
  logic             w_at_last;

  assign w_in_acc  = bus.in_valid & w_in_ready;
  assign w_out_acc = r_out_valid & bus.out_ready;
  assign w_at_last = (r_sel == LAST_SEL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL_A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL_A:  if (w_in_acc) w_state_nxt = FILL_B;
      FILL_B:  if (w_in_acc) w_state_nxt = EMIT;
      EMIT:    if (w_out_acc && w_at_last) w_state_nxt = FILL_A;
      default: w_state_nxt = FILL_A;
    endcase
  end

  // in_ready is masked by rst so a word offered during reset is never consumed
  always_comb begin
    w_in_ready = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      FILL_A:  w_in_ready = !rst;
      FILL_B:  begin w_in_ready = !rst; w_busy = 1'b1; end
      EMIT:    w_busy = 1'b1;
      default: w_in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_a    <= '0;
      r_data_b    <= '0;
      r_sel       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        FILL_A: begin
          if (w_in_acc) r_data_a <= bus.in_data;
        end
        FILL_B: begin
          if (w_in_acc) begin
            r_data_b    <= bus.in_data;
            r_sel       <= '0;
            r_out_valid <= 1'b1;
            r_out_last  <= (NUM_BEATS == 1);
          end
        end
        EMIT: begin
          // sel is left at its final value after the last beat
          if (w_out_acc) begin
            if (w_at_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end else begin
              r_sel      <= 5'(r_sel + 5'd1);
              r_out_last <= (5'(r_sel + 5'd1) == LAST_SEL);
            end
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.data_a    = r_data_a;
  assign bus.data_b    = r_data_b;
  assign bus.sel       = r_sel;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;

endmodule
